seven_seg_scan: RTL and testbench

Time-multiplexed driver for an N-digit common-anode seven-segment display. It generalises the team's single-digit hex decoder to NUM_DIGITS digits, with refresh scanning, per-frame snapshotting of the displayed value, leading-zero suppression, per-digit blanking, decimal points and an anti-ghosting blank interval. It sits between the datapath (which supplies packed hex nibbles) and the board display pins.

---
 rtl/seven_seg_scan.sv | 120 ++++++++++++
 tb/tb_seven_seg_scan.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan.sv
// Time-multiplexed N-digit common-anode seven-segment driver with per-frame snapshot,
// leading-zero suppression, per-digit blanking, decimal points and anti-ghosting blank slots.
module seven_seg_scan #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 0
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [4*NUM_DIGITS-1:0]                         value,
  input  logic [NUM_DIGITS-1:0]                           dp_in,
  input  logic [NUM_DIGITS-1:0]                           blank,
  input  logic                                            lz_en,
  output logic [6:0]                                      segs,
  output logic                                            dp,
  output logic [NUM_DIGITS-1:0]                           an,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
  output logic                                            frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  if (NUM_DIGITS < 1 || REFRESH_DIV < 1 || BLANK_CYC < 0 || BLANK_CYC >= REFRESH_DIV) begin : g_bad_params
    $error("seven_seg_scan: illegal parameters (need NUM_DIGITS>=1, REFRESH_DIV>=1, 0<=BLANK_CYC<REFRESH_DIV)");
  end

  // Active-high glyphs, bit6..bit0 = G..A.
  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0]        cnt;
  logic [4*NUM_DIGITS-1:0] sh_value;
  logic [NUM_DIGITS-1:0]   sh_dp;
  logic [NUM_DIGITS-1:0]   sh_blank;
  logic                    sh_lz;

  logic tick;
  logic wrap;
  logic in_blank;

  assign tick = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign wrap = tick && (digit_idx == IDX_W'(NUM_DIGITS - 1));

  if (BLANK_CYC == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (cnt < CNT_W'(BLANK_CYC));
  end

  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_off;
  logic [NUM_DIGITS-1:0] cur_onehot;
  logic                  zero_run;

  // Walk from the most significant digit down so zero_run means "this digit and all above are zero".
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_off    = 1'b0;
    cur_onehot = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (sh_value[4*i +: 4] == 4'h0);
      if (digit_idx == IDX_W'(i)) begin
        cur_nib       = sh_value[4*i +: 4];
        cur_dp        = sh_dp[i];
        cur_off       = sh_blank[i] || (sh_lz && zero_run && (i != 0));
        cur_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      digit_idx  <= '0;
      sh_value   <= '0;
      sh_dp      <= '0;
      sh_blank   <= '0;
      sh_lz      <= 1'b0;
      an         <= '1;
      segs       <= 7'h7F;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge state, as the hardware does.
      cnt        <= tick ? '0 : cnt + CNT_W'(1);
      frame_done <= wrap;
      if (tick) begin
        digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + IDX_W'(1);
      end
      // Snapshot on the wrap so the next frame's digit 0 already shows the new value.
      if (wrap) begin
        sh_value <= value;
        sh_dp    <= dp_in;
        sh_blank <= blank;
        sh_lz    <= lz_en;
      end
      if (in_blank || cur_off) begin
        an   <= '1;
        segs <= 7'h7F;
        dp   <= 1'b1;
      end else begin
        an   <= ~cur_onehot;
        segs <= ~glyph(cur_nib);
        dp   <= ~cur_dp;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan: table-driven frame checks plus reset, tearing
// and fast-scan sequences.
module tb_seven_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in, blank;
  logic        lz_en;
  logic [6:0]  segs;
  logic        dp;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  logic [15:0] value2  = 16'h0000;
  logic [3:0]  dp_in2  = 4'h0;
  logic [3:0]  blank2  = 4'h0;
  logic        lz_en2  = 1'b0;
  logic [6:0]  segs2;
  logic        dp2;
  logic [3:0]  an2;
  logic [1:0]  digit_idx2;
  logic        frame_done2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank(blank), .lz_en(lz_en),
    .segs(segs), .dp(dp), .an(an), .digit_idx(digit_idx), .frame_done(frame_done)
  );

  seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(1), .BLANK_CYC(0)) dut_fast (
    .clk(clk), .rst(rst), .value(value2), .dp_in(dp_in2), .blank(blank2), .lz_en(lz_en2),
    .segs(segs2), .dp(dp2), .an(an2), .digit_idx(digit_idx2), .frame_done(frame_done2)
  );

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    logic        lz_en;
    logic [3:0]  on;     // which digits light up
    logic [27:0] segs;   // expected active-low segs {d3,d2,d1,d0}
    logic [3:0]  dpo;    // expected active-low dp per digit while lit
  } vec_t;

  localparam int NV = 9;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_frame(input string name, input int budget);
    logic found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (frame_done === 1'b1) found = 1'b1;
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  // Called at the negedge where frame_done is seen; samples all 16 cycles of the next frame.
  task automatic check_frame(input int v, input vec_t t);
    logic [3:0] exp_an;
    logic [6:0] exp_segs;
    logic       exp_dp;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (c == 0 || !t.on[d]) begin
          exp_an = 4'hF; exp_segs = 7'h7F; exp_dp = 1'b1;
        end else begin
          exp_an = ~(4'b0001 << d); exp_segs = t.segs[7*d +: 7]; exp_dp = t.dpo[d];
        end
        check($sformatf("v%0d d%0d c%0d an", v, d, c), {28'd0, an}, {28'd0, exp_an});
        check($sformatf("v%0d d%0d c%0d segs", v, d, c), {25'd0, segs}, {25'd0, exp_segs});
        check($sformatf("v%0d d%0d c%0d dp", v, d, c), {31'd0, dp}, {31'd0, exp_dp});
        check($sformatf("v%0d d%0d c%0d idx", v, d, c), {30'd0, digit_idx}, 32'((d + (c == 3 ? 1 : 0)) % 4));
      end
    end
  endtask

  initial begin
    int first;
    vecs[0] = '{16'h12AF, 4'h0, 4'h0, 1'b0, 4'b1111, {7'b1111001, 7'b0100100, 7'b0001000, 7'b0001110}, 4'b1111};
    vecs[1] = '{16'h0030, 4'h0, 4'h0, 1'b1, 4'b0011, {7'h7F, 7'h7F, 7'b0110000, 7'b1000000}, 4'b1111};
    vecs[2] = '{16'h0000, 4'h0, 4'h0, 1'b1, 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'b1000000}, 4'b1111};
    vecs[3] = '{16'h0000, 4'h0, 4'h0, 1'b0, 4'b1111, {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}, 4'b1111};
    vecs[4] = '{16'h1111, 4'b0101, 4'b0100, 1'b0, 4'b1011, {7'b1111001, 7'h7F, 7'b1111001, 7'b1111001}, 4'b1110};
    vecs[5] = '{16'h0300, 4'b1000, 4'h0, 1'b1, 4'b0111, {7'h7F, 7'b0110000, 7'b1000000, 7'b1000000}, 4'b1111};
    vecs[6] = '{16'hC9E6, 4'b1111, 4'h0, 1'b0, 4'b1111, {7'b1000110, 7'b0010000, 7'b0000110, 7'b0000010}, 4'b0000};
    vecs[7] = '{16'h7B4D, 4'h0, 4'h0, 1'b1, 4'b1111, {7'b1111000, 7'b0000011, 7'b0011001, 7'b0100001}, 4'b1111};
    vecs[8] = '{16'h0805, 4'h0, 4'h0, 1'b1, 4'b0111, {7'h7F, 7'b0000000, 7'b1000000, 7'b0010010}, 4'b1111};

    rst = 1'b1; value = '0; dp_in = '0; blank = '0; lz_en = 1'b0;
    #1;
    check("reset an", {28'd0, an}, 32'hF);
    check("reset segs", {25'd0, segs}, 32'h7F);
    check("reset frame_done", {31'd0, frame_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Table-driven frames.
    for (int v = 0; v < NV; v++) begin
      value = vecs[v].value; dp_in = vecs[v].dp_in; blank = vecs[v].blank; lz_en = vecs[v].lz_en;
      wait_frame($sformatf("v%0d frame_done", v), 40);
      check_frame(v, vecs[v]);
    end

    // No tearing: a mid-frame change only shows from the next frame's digit 0.
    value = 16'h1111; dp_in = '0; blank = '0; lz_en = 1'b0;
    wait_frame("tear load", 40);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 2) value = 16'h2222;
      if (k <= 16) check($sformatf("tear k%0d frame_done", k), {31'd0, frame_done}, (k == 16) ? 32'd1 : 32'd0);
      if (k <= 16 && ((k - 1) % 4) != 0)
        check($sformatf("tear k%0d segs", k), {25'd0, segs}, {25'd0, 7'b1111001});
      if (k == 17) check("tear k17 an", {28'd0, an}, 32'hF);
      if (k == 18) begin
        check("tear k18 an", {28'd0, an}, 32'hE);
        check("tear k18 segs", {25'd0, segs}, {25'd0, 7'b0100100});
      end
    end

    // Asynchronous reset between edges, mid-scan.
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async rst an", {28'd0, an}, 32'hF);
    check("async rst segs", {25'd0, segs}, 32'h7F);
    check("async rst dp", {31'd0, dp}, 32'd1);
    check("async rst frame_done", {31'd0, frame_done}, 32'd0);
    check("async rst idx", {30'd0, digit_idx}, 32'd0);
    check("async rst fast an", {28'd0, an2}, 32'hF);
    @(negedge clk);
    rst = 1'b0;
    first = 0;
    for (int i = 1; i <= 40 && first == 0; i++) begin
      @(posedge clk); #1;
      if (frame_done === 1'b1) first = i;
      if (i == 2) begin
        check("post-rst zero an", {28'd0, an}, 32'hE);
        check("post-rst zero segs", {25'd0, segs}, {25'd0, 7'b1000000});
      end
    end
    check("first frame_done latency", first, 32'd16);

    // REFRESH_DIV=1, BLANK_CYC=0: anodes rotate every cycle.
    first = 0;
    for (int i = 0; i < 20 && first == 0; i++) begin
      @(negedge clk);
      if (frame_done2 === 1'b1) first = 1;
    end
    check("fast frame_done seen", first, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("fast k%0d an", k), {28'd0, an2}, {28'd0, ~(4'b0001 << (k % 4))});
      check($sformatf("fast k%0d segs", k), {25'd0, segs2}, {25'd0, 7'b1000000});
      check($sformatf("fast k%0d frame_done", k), {31'd0, frame_done2}, (k % 4 == 3) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
